div_unit: RTL and testbench
===========================

# div_unit

Multi-cycle 32-bit integer divider that produces the quotient/remainder pair written into the HI/LO register file for DIV/DIVU. Sits beside the EX-stage ALU: EX issues operands with a start strobe; the unit stalls the pipeline while iterating, then presents the write port (we/hi/lo) that the HI/LO register consumes.

## Interface
Parameters:
- none (width fixed at 32 via shared defines)

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-low
- start_i  in  1  request a division; sampled only in IDLE
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- annul_i  in  1  cancel in-flight op (exception/flush)
- stall_o  out  1  pipeline stall request
- we_o  out  1  one-cycle HI/LO write strobe
- hi_o  out  32  remainder
- lo_o  out  32  quotient

## Operation
- FSM states: IDLE, BYZERO, ON, END.
- IDLE: start_i=1 & annul_i=0 & opdata2_i=0 -> BYZERO; start_i=1 & annul_i=0 & divisor≠0 -> ON (latch |dividend|, |divisor| when signed_i, else raw; latch sign flags); else stay.
- BYZERO: -> END with result hi=0, lo=0.
- ON: restoring radix-2 division, one quotient bit per cycle, 6-bit counter 0..31; after 32nd iteration -> END with corrected result.
- Sign correction (signed_i=1 only): quotient negated when dividend and divisor signs differ; remainder takes sign of dividend. 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0 (wraps, no trap).
- END: we_o=1 for exactly this cycle, hi_o/lo_o valid; -> IDLE unconditionally.
- annul_i=1 in ON or BYZERO -> IDLE next edge, no we_o, partial result discarded. annul_i in END ignored (write already committed). annul_i with start_i in IDLE: request not accepted.
- start_i outside IDLE ignored; operands are latched, so input changes after acceptance have no effect.
- hi_o/lo_o hold last result after END until next END.
- Reset (any time, including mid-op): async -> IDLE; hi_o=0, lo_o=0, we_o=0, stall_o=0, counter=0.

## Timing
- stall_o = (IDLE & start_i & ~annul_i) | ON | BYZERO; combinational so EX stalls in the issue cycle; forced 0 while rst low. Low in END so the instruction advances with we_o.
- we_o, hi_o, lo_o are registered.
- Latency, divisor≠0: start sampled at edge N -> we_o high in cycle after edge N+33; stall_o high cycles N..N+32 (34 cycles including issue cycle counted from before edge N).
- Latency, divisor=0: start at edge N -> we_o high in cycle after edge N+2.
- Minimum start-to-start spacing: next start accepted in the first IDLE cycle after END.
- Annul in ON: stall_o drops the cycle after the annulling edge.

## Structure
- Shared defines header: DivFree/DivByZero/DivOn/DivEnd state codes, DivStart/DivStop, DivResultReady/NotReady, RegBus width, ZeroWord, RstEnable polarity for this block.
- Single module; the combinational sign-correct/abs logic stays inline. No sub-module needed.

## Test plan
- DIVU 100 / 7 -> after 33 cycles we_o pulse, lo=14, hi=2; stall_o high throughout, low in END cycle.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV 7 / 0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU same operands -> lo=0, hi=0x80000000.
- Divide by zero (any dividend) -> we_o 2 cycles after start edge, hi=0, lo=0.
- annul_i at iteration 10 -> no we_o, stall_o low next cycle; new start (DIVU 9/3) then completes lo=3, hi=0; start_i pulsed mid-op ignored.
- rst asserted mid-ON (async, between edges) -> outputs 0 immediately, FSM IDLE; after release, fresh op completes correctly.

Source files
------------

// File: rtl/div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : div_unit_pkg
// Brief   : Shared constants, state encoding and helpers for the HI/LO divider.
// Revision: 1.0 - initial release
// ============================================================================
package div_unit_pkg;

    localparam int          c_REG_BUS          = 32;
    localparam logic [31:0] c_ZERO_WORD        = 32'h0000_0000;
    localparam logic        c_RST_ENABLE       = 1'b0;

    localparam logic        c_DIV_START        = 1'b1;
    localparam logic        c_DIV_STOP         = 1'b0;
    localparam logic        c_RESULT_READY     = 1'b1;
    localparam logic        c_RESULT_NOT_READY = 1'b0;

    localparam logic [1:0]  c_DIV_FREE         = 2'b00;
    localparam logic [1:0]  c_DIV_BY_ZERO      = 2'b01;
    localparam logic [1:0]  c_DIV_ON           = 2'b10;
    localparam logic [1:0]  c_DIV_END          = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = c_DIV_FREE,
        ST_BYZERO = c_DIV_BY_ZERO,
        ST_ON     = c_DIV_ON,
        ST_END    = c_DIV_END
    } div_state_t;

    // Magnitude of a two's complement word; 0x80000000 maps to itself as unsigned.
    function automatic logic [c_REG_BUS-1:0] f_abs(input logic [c_REG_BUS-1:0] v);
        return v[c_REG_BUS-1] ? (c_ZERO_WORD - v) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : div_unit_if
// Brief   : EX-stage <-> divider operand/result bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface div_unit_if;
    import div_unit_pkg::*;

    logic                 start_i;
    logic                 signed_i;
    logic [c_REG_BUS-1:0] opdata1_i;
    logic [c_REG_BUS-1:0] opdata2_i;
    logic                 annul_i;
    logic                 stall_o;
    logic                 we_o;
    logic [c_REG_BUS-1:0] hi_o;
    logic [c_REG_BUS-1:0] lo_o;

    modport master (
        output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        input  stall_o, we_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        output stall_o, we_o, hi_o, lo_o
    );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module  : div_unit
// Brief   : Multi-cycle restoring radix-2 DIV/DIVU producing HI (rem) / LO (quo).
// Revision: 1.0 - initial release
// ============================================================================
module div_unit
    import div_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);

    div_state_t           r_state;
    logic [5:0]           r_cnt;
    logic [c_REG_BUS-1:0] r_rem;
    logic [c_REG_BUS-1:0] r_quo;
    logic [c_REG_BUS-1:0] r_dvs;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_we;
    logic [c_REG_BUS-1:0] r_hi;
    logic [c_REG_BUS-1:0] r_lo;

    logic [c_REG_BUS:0]   w_partial;
    logic [c_REG_BUS:0]   w_diff;
    logic [c_REG_BUS-1:0] w_q_final;
    logic [c_REG_BUS-1:0] w_r_final;
    logic                 w_accept;

    assign w_partial = {r_rem, r_quo[c_REG_BUS-1]};
    assign w_diff    = w_partial - {1'b0, r_dvs};
    assign w_q_final = r_neg_q ? (c_ZERO_WORD - r_quo) : r_quo;
    assign w_r_final = r_neg_r ? (c_ZERO_WORD - r_rem) : r_rem;
    assign w_accept  = (bus.start_i == c_DIV_START) && !bus.annul_i;

    assign bus.stall_o = (rst != c_RST_ENABLE) &&
                         (((r_state == ST_IDLE) && w_accept) ||
                          (r_state == ST_ON) || (r_state == ST_BYZERO));
    assign bus.we_o    = r_we;
    assign bus.hi_o    = r_hi;
    assign bus.lo_o    = r_lo;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == c_RST_ENABLE) begin
            r_state <= ST_IDLE;
            r_cnt   <= 6'd0;
            r_rem   <= c_ZERO_WORD;
            r_quo   <= c_ZERO_WORD;
            r_dvs   <= c_ZERO_WORD;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_we    <= c_RESULT_NOT_READY;
            r_hi    <= c_ZERO_WORD;
            r_lo    <= c_ZERO_WORD;
        end else begin
            r_we <= c_RESULT_NOT_READY;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= 6'd0;
                        r_rem   <= c_ZERO_WORD;
                        r_quo   <= bus.signed_i ? f_abs(bus.opdata1_i) : bus.opdata1_i;
                        r_dvs   <= bus.signed_i ? f_abs(bus.opdata2_i) : bus.opdata2_i;
                        r_neg_q <= bus.signed_i && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                        r_neg_r <= bus.signed_i && bus.opdata1_i[31];
                        r_state <= (bus.opdata2_i == c_ZERO_WORD) ? ST_BYZERO : ST_ON;
                    end
                end
                ST_BYZERO: begin
                    // Zero result rides the normal finishing edge of ON so both
                    // paths commit through the same registered write.
                    if (bus.annul_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_rem   <= c_ZERO_WORD;
                        r_quo   <= c_ZERO_WORD;
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                        r_cnt   <= 6'd32;
                        r_state <= ST_ON;
                    end
                end
                ST_ON: begin
                    if (bus.annul_i) begin
                        r_cnt   <= 6'd0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt != 6'd32) begin
                        if (!w_diff[c_REG_BUS]) begin
                            r_rem <= w_diff[c_REG_BUS-1:0];
                            r_quo <= {r_quo[c_REG_BUS-2:0], 1'b1};
                        end else begin
                            r_rem <= w_partial[c_REG_BUS-1:0];
                            r_quo <= {r_quo[c_REG_BUS-2:0], 1'b0};
                        end
                        r_cnt <= r_cnt + 6'd1;
                    end else begin
                        r_hi    <= w_r_final;
                        r_lo    <= w_q_final;
                        r_we    <= c_RESULT_READY;
                        r_cnt   <= 6'd0;
                        r_state <= ST_END;
                    end
                end
                ST_END: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_div_unit
// Brief   : Self-checking bench for div_unit against an arithmetic reference.
// Revision: 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic clk;
    logic rst;
    int   checks;
    int   fails;

    div_unit_if bus();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain SV arithmetic; signed uses truncating division.
    task automatic model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        if (b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;
            r  = sa % sb;
        end
    endtask

    task automatic run_op(input string tag, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input bit pulse_mid);
        logic [31:0] eq;
        logic [31:0] er;
        int          n;
        bit          stall_ok;
        model(sgn, a, b, eq, er);
        @(negedge clk);
        bus.start_i   = 1'b1;
        bus.signed_i  = sgn;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        #1;
        check({tag, ":issue_stall"}, 32'(bus.stall_o), 32'd1);
        @(posedge clk);
        #1;
        bus.start_i   = 1'b0;
        bus.signed_i  = 1'($urandom);
        bus.opdata1_i = $urandom;
        bus.opdata2_i = $urandom;
        n        = 0;
        stall_ok = 1'b1;
        while (!bus.we_o && n < 60) begin
            if (!bus.stall_o) stall_ok = 1'b0;
            if (pulse_mid) bus.start_i = (n == 5);
            @(posedge clk);
            #1;
            n++;
        end
        bus.start_i = 1'b0;
        check({tag, ":latency"}, 32'(n), (b == 32'd0) ? 32'd2 : 32'd33);
        check({tag, ":stall_busy"}, 32'(stall_ok), 32'd1);
        check({tag, ":we"}, 32'(bus.we_o), 32'd1);
        check({tag, ":stall_end"}, 32'(bus.stall_o), 32'd0);
        check({tag, ":lo"}, bus.lo_o, eq);
        check({tag, ":hi"}, bus.hi_o, er);
        @(posedge clk);
        #1;
        check({tag, ":we_pulse"}, 32'(bus.we_o), 32'd0);
        check({tag, ":lo_hold"}, bus.lo_o, eq);
    endtask

    initial begin
        int          wcount;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rs;
        checks        = 0;
        fails         = 0;
        rst           = 1'b0;
        bus.start_i   = 1'b1;
        bus.signed_i  = 1'b0;
        bus.opdata1_i = 32'd5;
        bus.opdata2_i = 32'd1;
        bus.annul_i   = 1'b0;
        #12;
        check("rst:stall", 32'(bus.stall_o), 32'd0);
        check("rst:we", 32'(bus.we_o), 32'd0);
        check("rst:hi", bus.hi_o, 32'd0);
        check("rst:lo", bus.lo_o, 32'd0);
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("div_by0", 1'b1, 32'h1234_5678, 32'd0, 1'b0);
        run_op("divu_by0", 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_op("div_midstart", 1'b1, 32'h8000_0000, 32'd3, 1'b1);

        // Annul at iteration 10
        @(negedge clk);
        bus.start_i   = 1'b1;
        bus.signed_i  = 1'b0;
        bus.opdata1_i = 32'd1000;
        bus.opdata2_i = 32'd9;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        check("annul:stall_drop", 32'(bus.stall_o), 32'd0);
        wcount = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.we_o || bus.stall_o) wcount++;
        end
        check("annul:no_write", 32'(wcount), 32'd0);
        run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 1'b0);

        // Asynchronous reset in the middle of an iteration
        @(negedge clk);
        bus.start_i   = 1'b1;
        bus.signed_i  = 1'b1;
        bus.opdata1_i = 32'd77;
        bus.opdata2_i = 32'd5;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("arst:stall", 32'(bus.stall_o), 32'd0);
        check("arst:we", 32'(bus.we_o), 32'd0);
        check("arst:hi", bus.hi_o, 32'd0);
        check("arst:lo", bus.lo_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wcount = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.we_o || bus.stall_o) wcount++;
        end
        check("arst:idle", 32'(wcount), 32'd0);
        run_op("post_rst", 1'b1, 32'hFFFF_FF85, 32'd10, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            if ((i % 6) == 0) ra = 32'h8000_0000;
            run_op($sformatf("rand%0d", i), rs, ra, rb, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
